// File: rtl/tiny16_pkg.sv
// ============================================================================
// Module   : tiny16_pkg
// Purpose  : Shared opcodes, FSM state encoding, in-mux codes and register
//            indices for the tiny16 control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tiny16_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDL  = 4'h2;
  localparam logic [3:0] OP_LDU  = 4'h3;
  localparam logic [3:0] OP_ALU  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_PUSH = 4'h7;
  localparam logic [3:0] OP_POP  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hB;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] IN_SRC = 2'd0;
  localparam logic [1:0] IN_ALU = 2'd1;
  localparam logic [1:0] IN_MEM = 2'd2;
  localparam logic [1:0] IN_IMM = 2'd3;

  localparam logic [3:0] REG_PC = 4'd1;
  localparam logic [3:0] REG_SP = 4'd2;
  localparam logic [3:0] REG_BP = 4'd3;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ============================================================================
// Module   : control_unit_if
// Purpose  : Instruction/data memory req/ack port between the control unit
//            (master) and the memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/control_unit_bus_watchdog.sv
// ============================================================================
// Module   : bus_watchdog
// Purpose  : Counts request cycles without ack; flags timeout when the count
//            reaches ACK_TIMEOUT (0 disables the watchdog).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_watchdog #(
  parameter int ACK_TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic req,
  input  wire logic ack,
  output logic      timeout
);

  generate
    if (ACK_TIMEOUT > 0) begin : g_wd_on
      localparam int W = $clog2(ACK_TIMEOUT + 1);
      logic [W-1:0] count;

      assign timeout = req && (count == W'(ACK_TIMEOUT));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          count <= '0;
        else if (req && !ack && !timeout)
          count <= count + 1'b1;
        else
          count <= '0;
      end
    end else begin : g_wd_off
      assign timeout = 1'b0;
      wire unused_wd = &{1'b0, clk, rst, req, ack};
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : tiny16 fetch/decode/execute/mem sequencer driving the register
//            file strobes and the memory req/ack port.
//            Optional: CTRL_ILLEGAL_TRAP_EN adds a sticky `illegal` output and
//            halts on opcodes C-F (otherwise they execute as NOP).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
  import tiny16_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  control_unit_if.master   mem,
  input  wire logic [15:0] rf_src,
  input  wire logic [15:0] rf_dst,
  input  wire logic        alu_zero,
  output logic [3:0]       src_sel,
  output logic [3:0]       dst_sel,
  output logic             in_en,
  output logic             up_en,
  output logic             lo_en,
  output logic             pc_inc,
  output logic             sp_inc,
  output logic             sp_dec,
  output logic [1:0]       in_sel,
  output logic [3:0]       alu_op,
  output logic             halted,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic             bus_err
);

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic        z;
  logic        halted_r, bus_err_r;
  logic        req_intent, timeout;
  logic [3:0]  op, fd, fs;

  assign op        = ir[15:12];
  assign fd        = ir[11:8];
  assign fs        = ir[7:4];
  assign alu_op    = ir[3:0];
  assign halted    = halted_r;
  assign bus_err   = bus_err_r;
  assign mem.mem_wdata = rf_src;
  assign req_intent = (state == ST_FETCH) || (state == ST_MEM);

  bus_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .req     (req_intent),
    .ack     (mem.mem_ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir        <= '0;
      z         <= 1'b0;
      halted_r  <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && mem.mem_ack && !timeout)
        ir <= mem.mem_rdata;
      if (state == ST_EXEC && op == OP_ALU)
        z <= alu_zero;
      if (state_nxt == ST_HALT)
        halted_r <= 1'b1;
      if (timeout)
        bus_err_r <= 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_r;
  assign illegal = illegal_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_r <= 1'b0;
    else if (state == ST_DECODE && is_illegal(op))
      illegal_r <= 1'b1;
  end
`endif

  // Outputs are held at reset values while rst is high, even though state is already FETCH.
  always_comb begin
    state_nxt    = state;
    src_sel      = 4'd0;
    dst_sel      = 4'd0;
    in_en        = 1'b0;
    up_en        = 1'b0;
    lo_en        = 1'b0;
    pc_inc       = 1'b0;
    sp_inc       = 1'b0;
    sp_dec       = 1'b0;
    in_sel       = IN_SRC;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_addr = 16'h0000;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          src_sel      = REG_PC;
          mem.mem_addr = rf_src;
          if (timeout) begin
            state_nxt = ST_HALT;
          end else begin
            mem.mem_req = 1'b1;
            if (mem.mem_ack) begin
              pc_inc    = 1'b1;
              state_nxt = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          src_sel = fs;
          dst_sel = fd;
          if (op == OP_HLT)
            state_nxt = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          else if (is_illegal(op))
            state_nxt = ST_HALT;
`endif
          else
            state_nxt = ST_EXEC;
        end
        ST_EXEC: begin
          src_sel   = fs;
          dst_sel   = fd;
          state_nxt = ST_FETCH;
          case (op)
            OP_MOV: in_en = 1'b1;
            OP_LDL: begin lo_en = 1'b1; in_sel = IN_IMM; end
            OP_LDU: begin up_en = 1'b1; in_sel = IN_IMM; end
            OP_ALU: begin in_en = 1'b1; in_sel = IN_ALU; end
            OP_LD, OP_ST, OP_PUSH: state_nxt = ST_MEM;
            OP_POP: begin sp_inc = 1'b1; state_nxt = ST_MEM; end
            OP_JMP: begin dst_sel = REG_PC; in_en = 1'b1; end
            OP_JZ:  begin dst_sel = REG_PC; in_en = z; end
            default: ;
          endcase
        end
        ST_MEM: begin
          src_sel = fs;
          dst_sel = fd;
          case (op)
            OP_LD:   mem.mem_addr = rf_src;
            OP_POP:  begin src_sel = REG_SP; mem.mem_addr = rf_src; end
            OP_ST:   begin mem.mem_we = 1'b1; mem.mem_addr = rf_dst; end
            OP_PUSH: begin mem.mem_we = 1'b1; dst_sel = REG_SP; mem.mem_addr = rf_dst; end
            default: ;
          endcase
          if (timeout) begin
            mem.mem_we = 1'b0;
            state_nxt  = ST_HALT;
          end else begin
            mem.mem_req = 1'b1;
            if (mem.mem_ack) begin
              state_nxt = ST_FETCH;
              if (op == OP_LD || op == OP_POP) begin
                in_en  = 1'b1;
                in_sel = IN_MEM;
              end
              if (op == OP_PUSH)
                sp_dec = 1'b1;
            end
          end
        end
        ST_HALT: ;
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire
